// File: rtl/sec_graph_loader.sv
// Graph loader: writes the checksummed monitoring graph into the basic-block
// and next-hop RAMs, holding the security monitor until the graph verifies.
module sec_graph_loader #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 32,
    parameter int MAX_ENTRIES = 2048
) (
    input  logic              core_sp_clk,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              cfg_ready,
    input  logic              cfg_abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] bbr_wdata,
    output logic [DATA_W-1:0] nhr_wdata,
    output logic [3:0]        bbr_we,
    output logic [3:0]        nhr_we,
    output logic              monitor_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [11:0]       entries_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BB,
        S_NH,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [11:0] MAX_N = 12'(MAX_ENTRIES);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] bbw_q, bbw_d;
    logic [DATA_W-1:0] nhw_q, nhw_d;
    logic [3:0]        we_q, we_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [11:0]       ent_q, ent_d;
    logic [11:0]       idx_q, idx_d;
    logic [11:0]       n_q, n_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] bb_q, bb_d;

    logic        fire;
    logic [11:0] hdr_n;
    logic        hdr_ok;

    // Abort gates ready only while a load is in progress.
    assign cfg_ready = ready_q && !(cfg_abort && busy_q);
    assign fire      = cfg_valid && cfg_ready;
    assign hdr_n     = cfg_data[11:0];
    assign hdr_ok    = (cfg_data[31:24] == 8'hA5) && (hdr_n != 12'd0)
                       && (hdr_n <= MAX_N);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bbw_d   = bbw_q;
        nhw_d   = nhw_q;
        we_d    = 4'h0;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = err_q;
        ent_d   = ent_q;
        idx_d   = idx_q;
        n_d     = n_q;
        acc_d   = acc_q;
        bb_d    = bb_q;

        unique case (state_q)
            S_IDLE: begin
                if (fire) begin
                    if (hdr_ok) begin
                        state_d = S_BB;
                        err_d   = 1'b0;
                        ent_d   = 12'd0;
                        idx_d   = 12'd0;
                        acc_d   = '0;
                        hold_d  = 1'b1;
                        n_d     = hdr_n;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                    end
                end
            end
            S_BB: begin
                if (cfg_abort) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                    hold_d  = 1'b1;
                end else if (fire) begin
                    bb_d    = cfg_data;
                    acc_d   = acc_q ^ cfg_data;
                    state_d = S_NH;
                end
            end
            S_NH: begin
                if (cfg_abort) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                    hold_d  = 1'b1;
                end else if (fire) begin
                    addr_d  = idx_q[ADDR_W-1:0];
                    bbw_d   = bb_q;
                    nhw_d   = cfg_data;
                    we_d    = 4'hF;
                    acc_d   = acc_q ^ cfg_data;
                    idx_d   = idx_q + 12'd1;
                    ent_d   = ent_q + 12'd1;
                    state_d = (idx_q == n_q - 12'd1) ? S_CSUM : S_BB;
                end
            end
            S_CSUM: begin
                if (cfg_abort) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                    hold_d  = 1'b1;
                end else if (fire) begin
                    if (cfg_data == acc_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d != S_DONE) && (state_d != S_ERROR);
        busy_d  = (state_d == S_BB) || (state_d == S_NH)
                  || (state_d == S_CSUM);
    end

    always_ff @(posedge core_sp_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            bbw_q   <= '0;
            nhw_q   <= '0;
            we_q    <= 4'h0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ent_q   <= 12'd0;
            idx_q   <= 12'd0;
            n_q     <= 12'd0;
            acc_q   <= '0;
            bb_q    <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            bbw_q   <= bbw_d;
            nhw_q   <= nhw_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ent_q   <= ent_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            bb_q    <= bb_d;
        end
    end

    assign mem_addr       = addr_q;
    assign bbr_wdata      = bbw_q;
    assign nhr_wdata      = nhw_q;
    assign bbr_we         = we_q;
    assign nhr_we         = we_q;
    assign monitor_hold   = hold_q;
    assign load_done      = done_q;
    assign load_error     = err_q;
    assign entries_loaded = ent_q;

endmodule

// File: doc/sec_graph_loader.md
# sec_graph_loader

Writes the monitoring graph into the security monitor's basic-block RAM and next-hop RAM from a 32-bit word stream on the core control path. It sits beside `sec_monitor`, driving the write side of the two graph memories. It holds the monitor inactive, via `monitor_hold`, until a complete, checksum-verified graph is resident.

## Interface
- `ADDR_W`, default 11: graph RAM word-address width (byte address bits [12:2]).
- `DATA_W`, default 32: graph word width.
- `MAX_ENTRIES`, default 2048: largest accepted entry count.

Ports:
- `core_sp_clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: a stream word is present.
- `cfg_data` in 32: stream word.
- `cfg_ready` out 1: loader accepts the word. A transfer occurs when `cfg_valid && cfg_ready` at a rising edge.
- `cfg_abort` in 1: abandon the current load.
- `mem_addr` out ADDR_W: write address, shared by both RAMs.
- `bbr_wdata` out 32: basic-block RAM write data.
- `nhr_wdata` out 32: next-hop RAM write data.
- `bbr_we` out 4: basic-block RAM byte enables.
- `nhr_we` out 4: next-hop RAM byte enables.
- `monitor_hold` out 1: when 1, the monitor must be held in reset.
- `load_done` out 1: one-cycle success pulse.
- `load_error` out 1: sticky failure flag.
- `entries_loaded` out 12: number of entry pairs written in the current or last load.

## Operation
Stream format:
- One header word: [31:24] = 8'hA5, [11:0] = entry count N, where 1 ≤ N ≤ MAX_ENTRIES.
- N pairs of words, each pair being bblock then nhop.
- One checksum word: the 32-bit XOR of all 2N payload words. The header is excluded from the checksum.

FSM states: IDLE, BB, NH, CSUM, DONE, ERROR.
- IDLE
  - A header transfer with valid magic and valid N goes to BB. On that transfer: clear `load_error`, clear `entries_loaded`, reset the index and the checksum accumulator to 0, and set `monitor_hold` = 1.
  - A malformed header (bad magic, N = 0, or N > MAX_ENTRIES) goes to ERROR.
- BB
  - A transfer latches the word into the bblock holding register, XORs it into the accumulator, and goes to NH.
- NH
  - A transfer registers the write: `mem_addr` = index, `bbr_wdata` = held bblock, `nhr_wdata` = the word, and both `we` = 4'hF.
  - On the same transfer: XOR the word into the accumulator, increment the index, and increment `entries_loaded`.
  - If the index before the increment was N-1, go to CSUM; otherwise go to BB.
- CSUM
  - A transfer where the word equals the accumulator goes to DONE.
  - A transfer where it differs goes to ERROR.
- DONE (1 cycle): `load_done` = 1, `monitor_hold` is cleared, then go to IDLE.
- ERROR (1 cycle): `load_error` is set, `monitor_hold` stays 1, then go to IDLE.
- `cfg_abort` = 1 in BB, NH, or CSUM goes to ERROR at the next edge. Abort takes priority over a simultaneous transfer, which is not accepted. `cfg_abort` is ignored in IDLE.
- `cfg_ready` = 1 in IDLE, BB, NH, and CSUM, and 0 in DONE and ERROR. In BB, NH, and CSUM it is also 0 while `cfg_abort` is high.
- Words already written are never rolled back. The graph is treated as invalid whenever `monitor_hold` = 1.

## Timing
- Reset values:
  - `monitor_hold` = 1, `cfg_ready` = 1.
  - `bbr_we` = `nhr_we` = 0, `mem_addr` = 0, `bbr_wdata` = `nhr_wdata` = 0.
  - `load_done` = 0, `load_error` = 0, `entries_loaded` = 0.
  - State = IDLE.
- All outputs are registered.
- The write strobe is valid for exactly the one cycle after the NH transfer edge. The `we` outputs are 0 in every other cycle.
- `load_done` and `load_error` changes and the `monitor_hold` update occur the cycle after the checksum transfer.
- `cfg_valid` gaps stall the FSM indefinitely. No timeout.
- Minimum load time: 2N+2 transfer cycles plus 1 DONE cycle.
- The index wraps nowhere: N ≤ MAX_ENTRIES bounds it to MAX_ENTRIES-1.
- Async reset mid-load returns all outputs to their reset values immediately, including any in-flight write strobe.

## Test plan
- Reset → `monitor_hold` = 1, `cfg_ready` = 1, `we` = 0, `entries_loaded` = 0.
- Good load of header 0xA5000002, then 0x10, 0x20, 0x30, 0x41, then checksum 0x41. Required response:
  - Writes addr 0 (bb 0x10, nh 0x20) and addr 1 (bb 0x30, nh 0x41).
  - `load_done` pulses once, `monitor_hold` → 0, `entries_loaded` = 2.
- Same stream with checksum 0x40 → both writes still occur, `load_error` = 1, `monitor_hold` = 1, no `load_done` pulse.
- Malformed headers → ERROR, no write strobes, `load_error` = 1:
  - Header 0x5A000001 (bad magic).
  - Header 0xA5000000 (N = 0).
  - Header 0xA5000801 (N = 2049).
- Disruptions mid-load:
  - `cfg_abort` asserted in NH after one pair → ERROR, `entries_loaded` = 1, `monitor_hold` = 1.
  - Async `reset` pulse during BB → all outputs at reset values.
- Full load with N = 2048 and random `cfg_valid` gaps → last write at `mem_addr` 2047, correct checksum accepted, exactly 2048 write strobes.
